skinscore_frame_stats: RTL and testbench
========================================

Name: skinscore_frame_stats

Overview:
- Sits directly downstream of the skin-tone datapath; consumes its per-pixel 8-bit skin score stream (valid-only, no backpressure) in raster order.
- Per frame: counts skin pixels (score >= threshold), sums scores and tracks the skin bounding box.
- Presents one result record per frame to a register/DMA consumer over a valid/ready handshake.

Parameters:
- IMG_W, 640, pixels per line.
- IMG_H, 480, lines per frame.
- COORD_W, 10, width of x/y coordinates; must satisfy 2^COORD_W >= max(IMG_W, IMG_H).
- CNT_W, 19, width of skin-pixel count; must satisfy 2^CNT_W > IMG_W*IMG_H.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- score_in  in  8  skin score from the datapath.
- score_in_valid  in  1  score_in qualifier; one pixel per asserted cycle.
- sof_in  in  1  start of frame; qualified by score_in_valid, marks pixel (0,0).
- thresh_in  in  8  skin threshold; sampled at each pixel.
- stats_valid  out  1  result record available.
- stats_ready  in  1  consumer accepts the record.
- skin_count  out  CNT_W  skin pixels in the frame.
- score_sum  out  CNT_W+8  sum of all scores in the frame.
- bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax  out  COORD_W each  inclusive skin bounding box.
- bbox_empty  out  1  no skin pixel in the frame.
- overrun  out  1  sticky: a record was overwritten before it was accepted.
- sync_err  out  1  sticky: sof_in arrived mid-frame.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; FSM enters IDLE; x/y counters, accumulators and sticky flags clear.
- FSM has two states:
  - IDLE: pixels are ignored until a valid pixel arrives with sof_in=1. That pixel is processed as (0,0) and the FSM moves to ACCUM.
  - ACCUM: each valid pixel advances x. When x=IMG_W-1, x wraps to 0 and y increments. The last pixel (IMG_W-1, IMG_H-1) is processed, then the FSM returns to IDLE.
- Skin test: score_in >= thresh_in (unsigned compare). On a skin pixel:
  - skin_count increments.
  - bbox min/max registers update with the current x/y.
  - The first skin pixel of a frame loads all four bbox registers.
- Sum: every valid pixel's score is added to the sum, skin or not, at full width; no saturation is needed given the widths.
- Frame completion (the cycle the last pixel is valid):
  - The next cycle, output registers hold the totals including the last pixel, and stats_valid=1.
  - Accumulators clear in the same cycle, so a back-to-back sof on the next cycle is handled with no bubble.
  - bbox_empty = (final count == 0); when empty, all bbox outputs = 0.
- Handshake:
  - The record is held stable while stats_valid && !stats_ready.
  - stats_valid drops the cycle after stats_valid && stats_ready.
- Overrun: if a frame completes while the previous record is still pending, the new record overwrites it, stats_valid stays 1 and overrun sets. If stats_ready is high in that same completion cycle, the old record counts as accepted and overrun does not set.
- Mid-frame sof: sof_in=1 on a valid pixel while in ACCUM and not at (0,0):
  - The partial frame is discarded with no record produced.
  - sync_err sets.
  - The pixel restarts the frame as (0,0).
- Cycles with score_in_valid=0 change nothing; arbitrary gaps between pixels are allowed.
- Latency: last pixel to stats_valid = 1 cycle.
- Sticky flags clear only on rst.

Optional Feature:
- SKINSTATS_SUM_EN defined: the score_sum adder and register are built as described above.
- Not defined: no sum logic is built and score_sum is driven constant 0. The port is present in both builds.

Decomposition:
- Shared package skinstats_pkg holds:
  - FSM state encoding (IDLE, ACCUM).
  - Default IMG_W, IMG_H, COORD_W and CNT_W values.
  - DEFAULT_THRESH = 8'd128, used by the top level to drive thresh_in.
- One sub-module, skinstats_bbox: owns the four min/max registers and the first-hit flag. Its inputs are clear, hit, x and y.

Test Plan (IMG_W=4, IMG_H=2, thresh_in=128):
- Sof, then 8 pixels with scores 0,200,0,0,0,0,150,0 -> next cycle stats_valid=1, skin_count=2, score_sum=350, bbox x 1..2, y 0..1, bbox_empty=0.
- All 8 scores = 127 -> skin_count=0, bbox_empty=1, all bbox=0, score_sum=1016.
- Complete a frame with stats_ready=0, then complete a second full frame -> overrun=1 and the record shows the second frame. Repeat with stats_ready=1 in the completion cycle -> overrun stays 0.
- Sof at pixel index 5 of a frame -> sync_err=1, no record produced; the following 8 pixels produce a correct record.
- Insert random score_in_valid gaps plus a back-to-back sof directly after the last pixel -> two correct records, no pixel lost.
- rst asserted mid-frame and while stats_valid=1 -> all outputs 0 the next cycle; the FSM waits for sof.

Source files
------------

// File: rtl/skinstats_pkg.sv
// Shared definitions for the per-frame skin statistics block: FSM encoding,
// default geometry and the default skin threshold.
package skinstats_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    localparam int DEF_IMG_W   = 640;
    localparam int DEF_IMG_H   = 480;
    localparam int DEF_COORD_W = 10;
    localparam int DEF_CNT_W   = 19;

    localparam logic [7:0] DEFAULT_THRESH = 8'd128;

endpackage

// File: rtl/skinstats_bbox.sv
// Skin bounding-box tracker: min/max x/y plus a first-hit flag.
// Outputs are the box merged with the current pixel (zero latency), state updates next edge.
module skinstats_bbox
    import skinstats_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               hit,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] xmin,
    output logic [COORD_W-1:0] xmax,
    output logic [COORD_W-1:0] ymin,
    output logic [COORD_W-1:0] ymax,
    output logic               found
);

    logic [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
    logic [COORD_W-1:0] xmin_d, xmax_d, ymin_d, ymax_d;
    logic               found_q, found_d, base_found;

    // clear discards history before the current pixel, so a hit on the same
    // cycle loads all four registers as the first skin pixel of a new frame.
    assign base_found = clear ? 1'b0 : found_q;

    always_comb begin
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        found_d = base_found;
        if (hit) begin
            found_d = 1'b1;
            if (!base_found) begin
                xmin_d = x;
                xmax_d = x;
                ymin_d = y;
                ymax_d = y;
            end else begin
                if (x < xmin_q) xmin_d = x;
                if (x > xmax_q) xmax_d = x;
                if (y < ymin_q) ymin_d = y;
                if (y > ymax_q) ymax_d = y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            found_q <= 1'b0;
        end else begin
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            found_q <= found_d;
        end
    end

    assign xmin  = xmin_d;
    assign xmax  = xmax_d;
    assign ymin  = ymin_d;
    assign ymax  = ymax_d;
    assign found = found_d;

endmodule

// File: rtl/skinscore_frame_stats.sv
// Per-frame skin statistics (count, score sum, bounding box) over a raster score stream.
// Latency: last pixel to stats_valid = 1 cycle; input has no backpressure, an unaccepted
// record is overwritten by the next frame (overrun). SKINSTATS_SUM_EN builds the score sum.
module skinscore_frame_stats
    import skinstats_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int COORD_W = DEF_COORD_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         score_in,
    input  logic               score_in_valid,
    input  logic               sof_in,
    input  logic [7:0]         thresh_in,
    output logic               stats_valid,
    input  logic               stats_ready,
    output logic [CNT_W-1:0]   skin_count,
    output logic [CNT_W+7:0]   score_sum,
    output logic [COORD_W-1:0] bbox_xmin,
    output logic [COORD_W-1:0] bbox_xmax,
    output logic [COORD_W-1:0] bbox_ymin,
    output logic [COORD_W-1:0] bbox_ymax,
    output logic               bbox_empty,
    output logic               overrun,
    output logic               sync_err
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

    state_e             state_q;
    logic [COORD_W-1:0] x_q, y_q, x_d, y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nxt;

    logic               sof_px, take, hit, last_px, mid_sof;
    logic [COORD_W-1:0] px_x, px_y;

    logic [COORD_W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic               bb_found;

    logic               stats_valid_q, bbox_empty_q, overrun_q, sync_err_q;
    logic [CNT_W-1:0]   skin_count_q;
    logic [COORD_W-1:0] bbox_xmin_q, bbox_xmax_q, bbox_ymin_q, bbox_ymax_q;

    // A valid sof pixel always restarts the frame at (0,0), from IDLE or mid-frame.
    assign sof_px  = score_in_valid && sof_in;
    assign take    = score_in_valid && ((state_q == ACCUM) || sof_in);
    assign px_x    = sof_px ? '0 : x_q;
    assign px_y    = sof_px ? '0 : y_q;
    assign hit     = take && (score_in >= thresh_in);
    assign last_px = take && (px_x == X_LAST) && (px_y == Y_LAST);
    assign mid_sof = sof_px && (state_q == ACCUM) && ((x_q != '0) || (y_q != '0));
    assign cnt_nxt = (sof_px ? '0 : cnt_q) + {{(CNT_W-1){1'b0}}, hit};

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        cnt_d = cnt_q;
        if (take) begin
            if (last_px) begin
                x_d   = '0;
                y_d   = '0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_nxt;
                if (px_x == X_LAST) begin
                    x_d = '0;
                    y_d = px_y + 1'b1;
                end else begin
                    x_d = px_x + 1'b1;
                    y_d = px_y;
                end
            end
        end
    end

    skinstats_bbox #(
        .COORD_W (COORD_W)
    ) u_bbox (
        .clk   (clk),
        .rst   (rst),
        .clear (sof_px),
        .hit   (hit),
        .x     (px_x),
        .y     (px_y),
        .xmin  (bb_xmin),
        .xmax  (bb_xmax),
        .ymin  (bb_ymin),
        .ymax  (bb_ymax),
        .found (bb_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            cnt_q         <= '0;
            stats_valid_q <= 1'b0;
            skin_count_q  <= '0;
            bbox_xmin_q   <= '0;
            bbox_xmax_q   <= '0;
            bbox_ymin_q   <= '0;
            bbox_ymax_q   <= '0;
            bbox_empty_q  <= 1'b0;
            overrun_q     <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE:    if (sof_px && !last_px) state_q <= ACCUM;
                ACCUM:   if (last_px) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            x_q   <= x_d;
            y_q   <= y_d;
            cnt_q <= cnt_d;

            if (mid_sof) sync_err_q <= 1'b1;

            if (last_px) begin
                stats_valid_q <= 1'b1;
                skin_count_q  <= cnt_nxt;
                bbox_empty_q  <= !bb_found;
                bbox_xmin_q   <= bb_found ? bb_xmin : '0;
                bbox_xmax_q   <= bb_found ? bb_xmax : '0;
                bbox_ymin_q   <= bb_found ? bb_ymin : '0;
                bbox_ymax_q   <= bb_found ? bb_ymax : '0;
                // Ready in the completion cycle means the old record was taken.
                if (stats_valid_q && !stats_ready) overrun_q <= 1'b1;
            end else if (stats_valid_q && stats_ready) begin
                stats_valid_q <= 1'b0;
            end
        end
    end

`ifdef SKINSTATS_SUM_EN
    logic [CNT_W+7:0] sum_q, sum_d, sum_nxt, sum_out_q;

    assign sum_nxt = (sof_px ? '0 : sum_q) + {{CNT_W{1'b0}}, score_in};

    always_comb begin
        sum_d = sum_q;
        if (take) sum_d = last_px ? '0 : sum_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q     <= '0;
            sum_out_q <= '0;
        end else begin
            sum_q <= sum_d;
            if (last_px) sum_out_q <= sum_nxt;
        end
    end

    assign score_sum = sum_out_q;
`else
    assign score_sum = '0;
`endif

    assign stats_valid = stats_valid_q;
    assign skin_count  = skin_count_q;
    assign bbox_xmin   = bbox_xmin_q;
    assign bbox_xmax   = bbox_xmax_q;
    assign bbox_ymin   = bbox_ymin_q;
    assign bbox_ymax   = bbox_ymax_q;
    assign bbox_empty  = bbox_empty_q;
    assign overrun     = overrun_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_skinscore_frame_stats.sv
// Directed bench for skinscore_frame_stats on a 4x2 frame with a record scoreboard.
module tb_skinscore_frame_stats;
    import skinstats_pkg::*;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int CW = 10;
    localparam int NW = 19;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    score_in;
    logic          score_in_valid;
    logic          sof_in;
    logic [7:0]    thresh_in;
    logic          stats_valid;
    logic          stats_ready;
    logic [NW-1:0] skin_count;
    logic [NW+7:0] score_sum;
    logic [CW-1:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
    logic          bbox_empty, overrun, sync_err;

    always #5 clk = ~clk;

    skinscore_frame_stats #(
        .IMG_W   (W),
        .IMG_H   (H),
        .COORD_W (CW),
        .CNT_W   (NW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .score_in       (score_in),
        .score_in_valid (score_in_valid),
        .sof_in         (sof_in),
        .thresh_in      (thresh_in),
        .stats_valid    (stats_valid),
        .stats_ready    (stats_ready),
        .skin_count     (skin_count),
        .score_sum      (score_sum),
        .bbox_xmin      (bbox_xmin),
        .bbox_xmax      (bbox_xmax),
        .bbox_ymin      (bbox_ymin),
        .bbox_ymax      (bbox_ymax),
        .bbox_empty     (bbox_empty),
        .overrun        (overrun),
        .sync_err       (sync_err)
    );

    typedef logic [7:0] frame_t [NPIX];

    typedef struct packed {
        logic [NW-1:0] cnt;
        logic [NW+7:0] sum;
        logic [CW-1:0] xmin;
        logic [CW-1:0] xmax;
        logic [CW-1:0] ymin;
        logic [CW-1:0] ymax;
        logic          empty;
    } rec_t;

    rec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    frame_t fa = '{8'd0, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd150, 8'd0};
    frame_t fb = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127};
    frame_t fc = '{8'd128, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    frame_t fd = '{8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd129};
    frame_t fr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected record computed directly from the whole frame in raster order.
    function automatic rec_t model(input frame_t f);
        rec_t r;
        int   x, y;
        r = '0;
        for (int i = 0; i < NPIX; i++) begin
            x = i % W;
            y = i / W;
            r.sum = r.sum + (NW+8)'(f[i]);
            if (f[i] >= DEFAULT_THRESH) begin
                if (r.cnt == 0) begin
                    r.xmin = CW'(x); r.xmax = CW'(x);
                    r.ymin = CW'(y); r.ymax = CW'(y);
                end else begin
                    if (CW'(x) < r.xmin) r.xmin = CW'(x);
                    if (CW'(x) > r.xmax) r.xmax = CW'(x);
                    if (CW'(y) < r.ymin) r.ymin = CW'(y);
                    if (CW'(y) > r.ymax) r.ymax = CW'(y);
                end
                r.cnt = r.cnt + 1'b1;
            end
        end
        r.empty = (r.cnt == 0);
`ifndef SKINSTATS_SUM_EN
        r.sum = '0;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [7:0] s, input logic sof);
        score_in       = s;
        sof_in         = sof;
        score_in_valid = 1'b1;
        tick();
        score_in_valid = 1'b0;
        sof_in         = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input int maxgap, input logic rdy_last);
        for (int i = 0; i < NPIX; i++) begin
            if (i == NPIX - 1) stats_ready = rdy_last;
            pix(f[i], i == 0);
            stats_ready = 1'b0;
            if (i < NPIX - 1 && maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
        end
        exp_q.push_back(model(f));
    endtask

    task automatic cmp_rec(input string tag, input rec_t e);
        chk({tag, ".count"}, 32'(skin_count), 32'(e.cnt));
        chk({tag, ".sum"},   32'(score_sum),  32'(e.sum));
        chk({tag, ".xmin"},  32'(bbox_xmin),  32'(e.xmin));
        chk({tag, ".xmax"},  32'(bbox_xmax),  32'(e.xmax));
        chk({tag, ".ymin"},  32'(bbox_ymin),  32'(e.ymin));
        chk({tag, ".ymax"},  32'(bbox_ymax),  32'(e.ymax));
        chk({tag, ".empty"}, 32'(bbox_empty), 32'(e.empty));
    endtask

    task automatic check_rec(input string tag);
        rec_t e;
        for (int k = 0; k < 20 && !stats_valid; k++) tick();
        chk({tag, ".valid"}, 32'(stats_valid), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            cmp_rec(tag, e);
        end
        stats_ready = 1'b1;
        tick();
        stats_ready = 1'b0;
        chk({tag, ".drop"}, 32'(stats_valid), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"},   32'(stats_valid), 32'd0);
        chk({tag, ".count"},   32'(skin_count),  32'd0);
        chk({tag, ".sum"},     32'(score_sum),   32'd0);
        chk({tag, ".bbox"},    32'({bbox_xmin, bbox_xmax, bbox_ymin}), 32'd0);
        chk({tag, ".ymax"},    32'(bbox_ymax),   32'd0);
        chk({tag, ".empty"},   32'(bbox_empty),  32'd0);
        chk({tag, ".overrun"}, 32'(overrun),     32'd0);
        chk({tag, ".syncerr"}, 32'(sync_err),    32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        score_in       = '0;
        score_in_valid = 1'b0;
        sof_in         = 1'b0;
        stats_ready    = 1'b0;
        thresh_in      = DEFAULT_THRESH;
        tick();
        tick();
        rst = 1'b0;
        chk_zero("reset");

        // Basic frame and all-below-threshold frame.
        send_frame(fa, 0, 1'b0);
        check_rec("frameA");
        send_frame(fb, 0, 1'b0);
        check_rec("frameB");

        // Overwrite of a pending record.
        send_frame(fc, 0, 1'b0);
        send_frame(fd, 0, 1'b0);
        void'(exp_q.pop_front());
        chk("ovr.set", 32'(overrun), 32'd1);
        check_rec("frameD");

        // Ready in the completion cycle: no overrun.
        do_reset();
        send_frame(fd, 0, 1'b0);
        cmp_rec("pendE", exp_q[0]);
        send_frame(fa, 0, 1'b1);
        void'(exp_q.pop_front());
        chk("ovr.clear", 32'(overrun), 32'd0);
        check_rec("frameF");

        // Mid-frame sof at pixel index 5.
        for (int i = 0; i < 5; i++) pix(8'd250, i == 0);
        chk("sync.pre", 32'(sync_err), 32'd0);
        send_frame(fc, 0, 1'b0);
        chk("sync.set", 32'(sync_err), 32'd1);
        check_rec("frameG");
        chk("sync.none", 32'(exp_q.size()), 32'd0);

        // Random gaps and a back-to-back sof after the last pixel.
        do_reset();
        for (int i = 0; i < NPIX; i++) fr[i] = 8'($urandom_range(0, 255));
        send_frame(fr, 3, 1'b0);
        for (int i = 0; i < NPIX; i++) fr[i] = 8'($urandom_range(0, 255));
        pix(fr[0], 1'b1);
        check_rec("frameH");
        for (int i = 1; i < NPIX; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            pix(fr[i], 1'b0);
        end
        exp_q.push_back(model(fr));
        check_rec("frameI");
        chk("gap.ovr", 32'(overrun), 32'd0);
        chk("gap.sync", 32'(sync_err), 32'd0);

        // Reset mid-frame, stray non-sof pixels are ignored afterwards.
        for (int i = 0; i < 3; i++) pix(8'd200, i == 0);
        do_reset();
        chk_zero("rstmid");
        pix(8'd200, 1'b0);
        pix(8'd200, 1'b0);
        tick();
        chk("idle.novalid", 32'(stats_valid), 32'd0);
        send_frame(fa, 1, 1'b0);
        check_rec("frameJ");

        // Reset while a record is pending.
        send_frame(fd, 0, 1'b0);
        void'(exp_q.pop_front());
        chk("pendK.valid", 32'(stats_valid), 32'd1);
        do_reset();
        chk_zero("rstvalid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
